param_file_register: RTL
========================

PARAM_FILE_REGISTER -- requirements
Module: param_file_register

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 16, meaning register count (power of two, >=2); localparam ADDR_W = $clog2(NUM_REGS).
REQ-003 SHALL have parameter RO_MASK, NUM_REGS bits, default 16'h1E01, meaning bit i set = register i read-only constant.
REQ-004 SHALL have parameter RO_VALUES, NUM_REGS*DATA_W bits, default r0=16'h0000, r9=16'h00FF, r10=16'h000F, r11=16'hFFF8, r12=16'h0002, meaning constant for register i at slice [i*DATA_W +: DATA_W].
REQ-005 SHALL have parameter IR_IDX, default NUM_REGS-1, meaning register driven onto bus_ir.
REQ-006 SHALL have ports: clk input 1 (single clock, rising edge); reset input 1 (asynchronous, active-low).
REQ-007 SHALL have ports: data_bus input DATA_W (write data); addr_d input ADDR_W (write address); rw input 1 (write enable, high = write).
REQ-008 SHALL have ports: addr_a, addr_b input ADDR_W (read addresses); bus_a, bus_b output DATA_W (read data); bus_ir output DATA_W.
REQ-009 SHALL have ports: clr_req input 1 (start clear sweep); busy output 1 (sweep in progress); clr_done output 1 (one-cycle completion pulse); ro_err output 1 (registered write-to-constant flag).

Function
REQ-010 Reads SHALL be combinational: bus_a = R[addr_a], bus_b = R[addr_b], bus_ir = R[IR_IDX]; RO registers read their RO_VALUES slice.
REQ-011 Write SHALL occur at rising clk when rw=1, busy=0, RO_MASK[addr_d]=0: R[addr_d] <= data_bus.
REQ-012 Write with RO_MASK[addr_d]=1 SHALL be discarded; ro_err SHALL be 1 the following cycle for exactly one cycle per offending write.
REQ-013 Clear FSM states: IDLE, SWEEP; IDLE->SWEEP on clr_req=1; SWEEP->IDLE when counter = NUM_REGS-1.
REQ-014 In SWEEP, counter (ADDR_W bits, starting 0) SHALL zero writable register R[counter] each cycle and increment; RO registers skipped without stalling; sweep lasts exactly NUM_REGS cycles.
REQ-015 busy SHALL be 1 in every SWEEP cycle; clr_done SHALL be 1 for the one cycle after the final SWEEP cycle.
REQ-016 rw while busy=1 SHALL be ignored (no write, no ro_err); caller must hold write until busy=0.
REQ-017 clr_req while busy=1 SHALL be ignored (no restart); clr_req on the clr_done cycle SHALL start a new sweep.
REQ-018 Reads SHALL remain valid during SWEEP, returning current (partially cleared) contents.

Reset
REQ-019 reset=0 SHALL asynchronously set every writable register to 0, FSM to IDLE, counter to 0, busy=0, clr_done=0, ro_err=0.
REQ-020 reset asserted mid-sweep SHALL abort the sweep; no clr_done SHALL follow release.
REQ-021 First write SHALL be accepted on the first rising edge with reset=1.

Configuration
REQ-022 Macro FILE_REGISTER_BYPASS_EN defined: when rw=1, busy=0, RO_MASK[addr_d]=0 and addr_a (or addr_b) = addr_d, bus_a (or bus_b) SHALL return data_bus in the same cycle (write-first); bus_ir unaffected.
REQ-023 Macro undefined: bus_a/bus_b SHALL return pre-write contents (read-first); no bypass logic present.

Structure
REQ-024 Shared package file_register_pkg SHALL hold default RO_MASK, default RO_VALUES and FSM state encodings (IDLE=0, SWEEP=1).
REQ-025 Clear FSM, counter, busy and clr_done SHALL be sub-module file_register_clear_seq (ports clk, reset, clr_req, busy, clr_done, sweep_addr, sweep_we).
REQ-026 Storage SHALL be generated only for writable indices; RO indices SHALL be constant drivers.

Verification
REQ-027 Write 16'hA5A5 to r3, then addr_a=3 -> bus_a=16'hA5A5 next cycle; bus_b with addr_b=9 -> 16'h00FF.
REQ-028 Write 16'h1234 to r11 -> r11 still reads 16'hFFF8; ro_err=1 exactly one cycle later.
REQ-029 Fill r1..r8,r13..r15 with nonzero, pulse clr_req -> busy=1 for 16 cycles, clr_done pulse, all writable read 0, constants unchanged.
REQ-030 rw=1 to r5 with 16'hBEEF during sweep -> r5 reads 0 after sweep; ro_err stays 0.
REQ-031 addr_a=addr_d=4, rw=1, data_bus=16'h0F0F, r4 previously 16'h1111 -> bus_a=16'h0F0F with FILE_REGISTER_BYPASS_EN, 16'h1111 without.
REQ-032 Assert reset at sweep cycle 7 -> busy=0 immediately, writable all 0, no clr_done after release; repeat with NUM_REGS=32, DATA_W=32.

Source files
------------

// File: rtl/file_register_pkg.sv
// file_register_pkg: default constant-register map and clear-FSM state encoding
package file_register_pkg;
  localparam logic [15:0] DEF_RO_MASK = 16'h1E01;
  localparam logic [255:0] DEF_RO_VALUES = {
    16'h0000, 16'h0000, 16'h0000, 16'h0002, 16'hFFF8, 16'h000F, 16'h00FF, {9{16'h0000}}
  };
  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} clr_state_t;
endpackage

// File: rtl/file_register_clear_seq.sv
// file_register_clear_seq: walks every register index once to zero the file, then pulses done
module file_register_clear_seq
  import file_register_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] sweep_addr,
  output logic              sweep_we
);
  clr_state_t        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_busy;
  logic              r_done;
  // Sweep FSM: start on request when idle, one index per cycle, done pulse after the last index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (clr_req) begin
          r_state <= SWEEP;
          r_busy  <= 1'b1;
          r_cnt   <= '0;
        end
      end else begin
        r_cnt <= r_cnt + ADDR_W'(1);
        if (r_cnt == ADDR_W'(NUM_REGS - 1)) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
      end
    end
  end
  assign busy       = r_busy;
  assign clr_done   = r_done;
  assign sweep_addr = r_cnt;
  assign sweep_we   = r_busy;
endmodule

// File: rtl/param_file_register.sv
// param_file_register: register file with constant entries, clear sweep and write-to-constant flag
// Optional macro FILE_REGISTER_BYPASS_EN: write-first forwarding of data_bus onto bus_a/bus_b.
module param_file_register
  import file_register_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = NUM_REGS'(DEF_RO_MASK),
  parameter logic [NUM_REGS*DATA_W-1:0] RO_VALUES = (NUM_REGS*DATA_W)'(DEF_RO_VALUES),
  parameter int IR_IDX = NUM_REGS - 1,
  localparam int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_bus,
  input  logic [ADDR_W-1:0] addr_d,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] bus_a,
  output logic [DATA_W-1:0] bus_b,
  output logic [DATA_W-1:0] bus_ir,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  output logic              ro_err
);
  logic [DATA_W-1:0] w_regs [NUM_REGS];
  logic              w_busy;
  logic              w_sweep_we;
  logic [ADDR_W-1:0] w_sweep_addr;
  logic              w_wr;
  logic              r_ro_err;

  file_register_clear_seq #(.NUM_REGS(NUM_REGS)) u_clr (
    .clk       (clk),
    .reset     (reset),
    .clr_req   (clr_req),
    .busy      (w_busy),
    .clr_done  (clr_done),
    .sweep_addr(w_sweep_addr),
    .sweep_we  (w_sweep_we)
  );

  assign w_wr = rw & ~w_busy;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (RO_MASK[i]) begin : g_ro
      assign w_regs[i] = RO_VALUES[i*DATA_W +: DATA_W];
    end else begin : g_rw
      logic [DATA_W-1:0] r_q;
      // Writable cell: the sweep zeroes it, otherwise an accepted bus write loads it
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_q <= '0;
        else if (w_sweep_we && w_sweep_addr == ADDR_W'(i)) r_q <= '0;
        else if (w_wr && addr_d == ADDR_W'(i)) r_q <= data_bus;
      end
      assign w_regs[i] = r_q;
    end
  end

  // Flag a write aimed at a constant register for the following cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_ro_err <= 1'b0;
    else r_ro_err <= w_wr & RO_MASK[addr_d];
  end

`ifdef FILE_REGISTER_BYPASS_EN
  logic w_byp;
  assign w_byp = w_wr & ~RO_MASK[addr_d];
  assign bus_a = (w_byp && addr_a == addr_d) ? data_bus : w_regs[addr_a];
  assign bus_b = (w_byp && addr_b == addr_d) ? data_bus : w_regs[addr_b];
`else
  assign bus_a = w_regs[addr_a];
  assign bus_b = w_regs[addr_b];
`endif
  assign bus_ir = w_regs[IR_IDX];
  assign busy   = w_busy;
  assign ro_err = r_ro_err;
endmodule
